// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard/sequencing control for the 5-stage MIPS pipeline. Produces the
//   load enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers, plus synchronous flush (bubble) controls. It also tracks a
//   pending wrong-path fetch after a redirect, a sticky halt, and a
//   saturating stall-cycle counter.
//
// Ports
//   CLK, nRST                 clock / asynchronous active-low reset
//   ihit, dhit                icache / dcache handshakes
//   mem_dREN, mem_dWEN        MEM-stage data access in flight
//   idex_memread, idex_rt     EX-stage load and its destination register
//   ifid_rs, ifid_rt          ID-stage source registers
//   jump_id, branch_taken_mem control redirects (ID / MEM)
//   halt_mem                  HALT instruction reached MEM
//   pc_en, *_en               register load enables
//   *_flush                   register clears (a flush wins over the enable)
//   halted                    sticky halt indication
//   stall_cnt                 cycles with pc_en=0 outside HALT, saturating
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             jump_id,
  input  logic             branch_taken_mem,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_HALT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic dstall, load_use;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c, halted_c;

  assign dstall   = (mem_dREN | mem_dWEN) & ~dhit;
  // Register 0 is hardwired to zero, so a load targeting it never conflicts.
  assign load_use = idex_memread && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  always_comb begin
    state_d       = state_q;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    exmem_en_c    = 1'b0;
    memwb_en_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    halted_c      = 1'b0;

    if (state_q == ST_HALT) begin
      halted_c = 1'b1;
    end else if (dstall) begin
      // Whole pipe frozen; any redirect/halt stays put and is seen again.
    end else if (halt_mem) begin
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
      {ifid_flush_c, idex_flush_c, exmem_flush_c}             = '1;
      state_d = ST_HALT;
    end else if (branch_taken_mem) begin
      // Older instruction wins over a same-cycle jump; the jump is flushed.
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
      {ifid_flush_c, idex_flush_c, exmem_flush_c}             = '1;
      state_d = ihit ? ST_RUN : ST_PEND;
    end else if (jump_id) begin
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
      ifid_flush_c = 1'b1;
      state_d = ihit ? ST_RUN : ST_PEND;
    end else if (load_use) begin
      idex_en_c    = 1'b1;
      exmem_en_c   = 1'b1;
      memwb_en_c   = 1'b1;
      idex_flush_c = 1'b1;
      // IF/ID is not loaded, so a stale word returning now is dropped anyway.
      if (state_q == ST_PEND && ihit) state_d = ST_RUN;
    end else if (!ihit) begin
      idex_en_c    = 1'b1;
      exmem_en_c   = 1'b1;
      memwb_en_c   = 1'b1;
      idex_flush_c = 1'b1;
    end else begin
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
      if (state_q == ST_PEND) begin
        // This word belongs to the pre-redirect path: discard it.
        ifid_flush_c = 1'b1;
        state_d      = ST_RUN;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != ST_HALT && !pc_en_c && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign pc_en       = nRST & pc_en_c;
  assign ifid_en     = nRST & ifid_en_c;
  assign idex_en     = nRST & idex_en_c;
  assign exmem_en    = nRST & exmem_en_c;
  assign memwb_en    = nRST & memwb_en_c;
  assign ifid_flush  = nRST & ifid_flush_c;
  assign idex_flush  = nRST & idex_flush_c;
  assign exmem_flush = nRST & exmem_flush_c;
  assign halted      = nRST & halted_c;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Control outputs are packed as
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//  ifid_flush, idex_flush, exmem_flush, halted}.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;
  localparam int REG_W = 5;

  localparam logic [8:0] O_RUN  = 9'b11111_000_0; // normal flow
  localparam logic [8:0] O_BUB  = 9'b00111_010_0; // hold PC/IFID, bubble EX
  localparam logic [8:0] O_FRZ  = 9'b00000_000_0; // everything frozen
  localparam logic [8:0] O_BR   = 9'b11111_111_0; // branch / halt flush
  localparam logic [8:0] O_JMP  = 9'b11111_100_0; // jump / stale fetch drop
  localparam logic [8:0] O_HALT = 9'b00000_000_1;

  logic CLK, nRST;
  logic ihit, dhit, mem_dREN, mem_dWEN, idex_memread;
  logic [REG_W-1:0] idex_rt, ifid_rs, ifid_rt;
  logic jump_id, branch_taken_mem, halt_mem;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, halted;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .jump_id(jump_id), .branch_taken_mem(branch_taken_mem),
    .halt_mem(halt_mem), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halted(halted), .stall_cnt(stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, halted};
  endfunction

  // Advance one clock, then let inputs be changed away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic co(input string tag, input logic [8:0] exp);
    #1;
    chk(tag, 32'(outs()), 32'(exp));
  endtask

  initial begin
    nRST = 1'b0; ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0;
    idex_memread = 0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    jump_id = 0; branch_taken_mem = 0; halt_mem = 0;

    // Reset held: outputs quiet even with ihit high.
    #8 ihit = 1;
    co("rst_outs", O_FRZ);
    chk("rst_cnt", stall_cnt, 0);
    #3 nRST = 1'b1;

    // Plain flow for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      co("run_outs", O_RUN);
      tick();
    end
    chk("run_cnt", stall_cnt, 0);

    // Load-use on rs.
    idex_memread = 1; idex_rt = 5'd8; ifid_rs = 5'd8;
    co("lu_rs_outs", O_BUB);
    tick();
    chk("lu_rs_cnt", stall_cnt, 1);
    // Destination $0 never stalls.
    idex_rt = 5'd0; ifid_rs = 5'd0;
    co("lu_r0_outs", O_RUN);
    tick();
    chk("lu_r0_cnt", stall_cnt, 1);
    // Load-use on rt.
    idex_rt = 5'd5; ifid_rs = 5'd3; ifid_rt = 5'd5;
    co("lu_rt_outs", O_BUB);
    tick();
    chk("lu_rt_cnt", stall_cnt, 2);
    idex_memread = 0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;

    // Dcache miss for 3 cycles, branch appears mid-stall.
    mem_dREN = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) branch_taken_mem = 1;
      co("dstall_outs", O_FRZ);
      tick();
    end
    chk("dstall_cnt", stall_cnt, 5);
    dhit = 1;
    co("dhit_br_outs", O_BR);
    tick();
    chk("dhit_br_cnt", stall_cnt, 5);
    mem_dREN = 0; dhit = 0; branch_taken_mem = 0;
    co("post_br_outs", O_RUN);

    // Jump with icache miss -> PEND, then stale word dropped.
    jump_id = 1; ihit = 0;
    co("jmp_outs", O_JMP);
    tick();
    jump_id = 0;
    for (int i = 0; i < 2; i++) begin
      co("pend_miss_outs", O_BUB);
      tick();
    end
    chk("pend_cnt", stall_cnt, 7);
    ihit = 1;
    co("pend_hit_outs", O_JMP);
    tick();
    co("pend_back_run", O_RUN);
    chk("pend_end_cnt", stall_cnt, 7);

    // Branch and jump together: branch wins, stays RUN.
    branch_taken_mem = 1; jump_id = 1;
    co("br_jmp_outs", O_BR);
    tick();
    branch_taken_mem = 0; jump_id = 0;
    co("br_jmp_after", O_RUN);

    // Plain icache miss in RUN.
    ihit = 0;
    co("imiss_outs", O_BUB);
    tick();
    chk("imiss_cnt", stall_cnt, 8);
    ihit = 1;

    // Halt.
    halt_mem = 1;
    co("halt_req_outs", O_BR);
    tick();
    halt_mem = 0;
    co("halted_outs", O_HALT);
    tick();
    tick();
    co("halted_hold", O_HALT);
    chk("halted_cnt", stall_cnt, 8);

    // Asynchronous reset mid-HALT.
    nRST = 1'b0;
    co("halt_rst_outs", O_FRZ);
    chk("halt_rst_cnt", stall_cnt, 0);
    #2 nRST = 1'b1;
    tick();
    co("after_rst_outs", O_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim did not complete");
    $fatal(1);
  end

endmodule
